cnn_mac_pipe: RTL and testbench

- Parametrised, pipelined signed multiply-accumulate unit for the CNN convolution and dense datapaths.
- Supersedes the fixed-width single-stage combinational multiplier.
- Operand widths, multiplier pipeline depth, accumulator width and the overflow mode (saturate or wrap) are all configurable.
- Groups of products (one kernel window / dot product) are marked by first/last flags; one result is emitted per group.
- A clock-enable stalls the whole pipeline.

---
 rtl/cnn_mac_pipe.sv | 142 ++++++++++++++
 tb/tb_cnn_mac_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined signed multiply-accumulate for the CNN datapaths.
// Operands are registered, the exact product travels through NUM_STAGE
// registers with its group flags, and a single accumulate stage sums each
// group, emitting one result (with overflow flag) on the group's last beat.
module cnn_mac_pipe #(
    parameter int A_WIDTH   = 10,
    parameter int B_WIDTH   = 14,
    parameter int ACC_WIDTH = 32,
    parameter int NUM_STAGE = 3,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] dout,
    output logic                 ovf
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    generate
        if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_bad_acc_width
            $error("cnn_mac_pipe: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
        end
        if (NUM_STAGE < 1) begin : g_bad_num_stage
            $error("cnn_mac_pipe: NUM_STAGE must be >= 1");
        end
    endgenerate

    logic [A_WIDTH-1:0]        a_q;
    logic [B_WIDTH-1:0]        b_q;
    logic                      v_q;
    logic                      f_q;
    logic                      l_q;
    logic signed [P_WIDTH-1:0] prod;

    logic signed [P_WIDTH-1:0] p_pipe [NUM_STAGE];
    logic [NUM_STAGE-1:0]      v_pipe;
    logic [NUM_STAGE-1:0]      f_pipe;
    logic [NUM_STAGE-1:0]      l_pipe;

    logic signed [ACC_WIDTH-1:0] acc;
    logic                        sticky;
    logic                        in_group;

    logic                        restart;
    logic signed [ACC_WIDTH-1:0] p_ext;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH:0]   sum;
    logic                        of;
    logic signed [ACC_WIDTH-1:0] result;
    logic                        grp_of;

    assign prod = P_WIDTH'($signed(a_q)) * P_WIDTH'($signed(b_q));

    // Operand and flag capture; inputs are only sampled in ce=1 cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
            f_q <= 1'b0;
            l_q <= 1'b0;
        end else if (ce) begin
            a_q <= din0;
            b_q <= din1;
            v_q <= in_valid;
            f_q <= in_first;
            l_q <= in_last;
        end
    end

    // Product shift pipeline carrying valid/first/last alongside the product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                p_pipe[i] <= '0;
            end
            v_pipe <= '0;
            f_pipe <= '0;
            l_pipe <= '0;
        end else if (ce) begin
            p_pipe[0] <= prod;
            v_pipe[0] <= v_q;
            f_pipe[0] <= f_q;
            l_pipe[0] <= l_q;
            for (int unsigned i = 1; i < NUM_STAGE; i++) begin
                p_pipe[i] <= p_pipe[i-1];
                v_pipe[i] <= v_pipe[i-1];
                f_pipe[i] <= f_pipe[i-1];
                l_pipe[i] <= l_pipe[i-1];
            end
        end
    end

    // Group sum: pick base, add at ACC_WIDTH+1 bits, detect and resolve overflow.
    always_comb begin
        restart = f_pipe[NUM_STAGE-1] || !in_group;
        p_ext   = ACC_WIDTH'(p_pipe[NUM_STAGE-1]);
        base    = restart ? '0 : acc;
        sum     = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(p_ext);
        of      = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
        result  = sum[ACC_WIDTH-1:0];
        if (of && SATURATE != 0) begin
            result = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        grp_of  = (restart ? 1'b0 : sticky) | of;
    end

    // Accumulator state and registered group result; in_group=0 forces a restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            sticky    <= 1'b0;
            in_group  <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= 1'b0;
            if (v_pipe[NUM_STAGE-1]) begin
                acc      <= result;
                sticky   <= grp_of;
                in_group <= !l_pipe[NUM_STAGE-1];
                if (l_pipe[NUM_STAGE-1]) begin
                    out_valid <= 1'b1;
                    dout      <= result;
                    ovf       <= grp_of;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Self-checking bench for cnn_mac_pipe: three instances (default 32-bit
// saturating, 24-bit saturating, 24-bit wrapping) share one stimulus stream.
// A group-level arithmetic model predicts every result and the edge it
// appears on; a directed table adds hand-computed expected group sums.
module tb_cnn_mac_pipe;

    localparam int NS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_first;
    logic        in_last;
    logic [9:0]  din0;
    logic [13:0] din1;

    logic        ov0, ov1, ov2;
    logic [31:0] d0;
    logic [23:0] d1, d2;
    logic        f0, f1, f2;

    always #5 clk = ~clk;

    cnn_mac_pipe #(.A_WIDTH(10), .B_WIDTH(14), .ACC_WIDTH(32), .NUM_STAGE(NS), .SATURATE(1)) dut_def (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov0), .dout(d0), .ovf(f0));

    cnn_mac_pipe #(.A_WIDTH(10), .B_WIDTH(14), .ACC_WIDTH(24), .NUM_STAGE(NS), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov1), .dout(d1), .ovf(f1));

    cnn_mac_pipe #(.A_WIDTH(10), .B_WIDTH(14), .ACC_WIDTH(24), .NUM_STAGE(NS), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov2), .dout(d2), .ovf(f2));

    typedef struct {
        int     inst;
        int     edge_n;
        longint d;
        bit     o;
    } exp_t;

    typedef struct {
        bit     ce, v, f, l;
        int     a, b;
        bit     chk;
        longint ed0, ed1, ed2;
        bit     eo0, eo1, eo2;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    int     k = 0;
    bit     tmode = 1'b1;
    longint m_acc [3];
    bit     m_ovf [3];
    bit     m_grp [3];
    exp_t   eq[$];
    exp_t   tq[$];

    function automatic int accw(int i);
        return (i == 0) ? 32 : 24;
    endfunction

    function automatic bit sat(int i);
        return i != 2;
    endfunction

    function automatic logic get_v(int i);
        case (i)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic get_o(int i);
        case (i)
            0:       return f0;
            1:       return f1;
            default: return f2;
        endcase
    endfunction

    function automatic logic signed [63:0] get_d(int i);
        case (i)
            0:       return 64'($signed(d0));
            1:       return 64'($signed(d1));
            default: return 64'($signed(d2));
        endcase
    endfunction

    task automatic check(string name, int i, logic signed [63:0] got, logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d edge %0d: got %0d expected %0d", name, i, k, got, want);
        end
    endtask

    // Group-level model: running integer sum per group, clamped or wrapped to
    // the accumulator range; a result is due NS+1 enabled edges after acceptance.
    function automatic void model_beat(int i, longint p, bit f, bit l);
        longint one;
        longint mx;
        longint mn;
        longint s;
        bit     o;
        one = 1;
        mx  = (one << (accw(i) - 1)) - 1;
        mn  = -mx - 1;
        if (f || !m_grp[i]) begin
            s = 0;
            o = 1'b0;
        end else begin
            s = m_acc[i];
            o = m_ovf[i];
        end
        s = s + p;
        if (s > mx) begin
            o = 1'b1;
            s = sat(i) ? mx : s - 2 * (mx + 1);
        end else if (s < mn) begin
            o = 1'b1;
            s = sat(i) ? mn : s + 2 * (mx + 1);
        end
        m_acc[i] = s;
        m_ovf[i] = o;
        m_grp[i] = !l;
        if (l) eq.push_back('{inst: i, edge_n: k + NS + 1, d: s, o: o});
    endfunction

    task automatic check_inst(int i);
        bit   found;
        int   idx;
        exp_t e;
        found = 1'b0;
        idx   = 0;
        e     = '{0, 0, 0, 1'b0};
        foreach (eq[j]) begin
            if (!found && eq[j].inst == i && eq[j].edge_n == k) begin
                found = 1'b1;
                idx   = j;
                e     = eq[j];
            end
        end
        if (found) eq.delete(idx);
        check("out_valid", i, get_v(i), found);
        if (found) begin
            check("dout", i, get_d(i), e.d);
            check("ovf", i, get_o(i), e.o);
        end
        if (get_v(i) === 1'b1 && tmode) begin
            found = 1'b0;
            foreach (tq[j]) begin
                if (!found && tq[j].inst == i) begin
                    found = 1'b1;
                    idx   = j;
                    e     = tq[j];
                end
            end
            if (found) begin
                tq.delete(idx);
                check("tbl_dout", i, get_d(i), e.d);
                check("tbl_ovf", i, get_o(i), e.o);
            end
        end
    endtask

    // Reference update and output comparison on every enabled, non-reset edge.
    always @(posedge clk) begin
        if (!reset && ce) begin
            k++;
            if (in_valid) begin
                longint p;
                p = longint'($signed(din0)) * longint'($signed(din1));
                for (int i = 0; i < 3; i++) model_beat(i, p, in_first, in_last);
            end
            #1;
            for (int i = 0; i < 3; i++) check_inst(i);
        end
    end

    // Reset discards everything in flight.
    always @(posedge reset) begin
        eq.delete();
        for (int i = 0; i < 3; i++) m_grp[i] = 1'b0;
    end

    function automatic vec_t mk(input bit c, v, f, l, input int a, b, input bit chk = 1'b0,
                                input longint e0 = 0, input bit o0 = 1'b0,
                                input longint e1 = 0, input bit o1 = 1'b0,
                                input longint e2 = 0, input bit o2 = 1'b0);
        vec_t r;
        r.ce = c; r.v = v; r.f = f; r.l = l; r.a = a; r.b = b; r.chk = chk;
        r.ed0 = e0; r.ed1 = e1; r.ed2 = e2; r.eo0 = o0; r.eo1 = o1; r.eo2 = o2;
        return r;
    endfunction

    task automatic apply(vec_t r);
        @(negedge clk);
        ce       = r.ce;
        in_valid = r.v;
        in_first = r.f;
        in_last  = r.l;
        din0     = 10'(r.a);
        din1     = 14'(r.b);
        if (r.chk) begin
            tq.push_back('{0, 0, r.ed0, r.eo0});
            tq.push_back('{1, 0, r.ed1, r.eo1});
            tq.push_back('{2, 0, r.ed2, r.eo2});
        end
    endtask

    task automatic idle(int n);
        repeat (n) apply(mk(1, 0, 0, 0, 0, 0));
    endtask

    task automatic check_zero(string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_valid"}, i, get_v(i), 0);
            check({tag, "_dout"}, i, get_d(i), 0);
            check({tag, "_ovf"}, i, get_o(i), 0);
        end
    endtask

    initial begin
        vec_t tbl[$];
        reset = 1'b1; ce = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        din0 = '0; din1 = '0;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_ovf[i] = 1'b0; m_grp[i] = 1'b0;
        end

        // single-element group at operand extremes
        tbl.push_back(mk(1, 1, 1, 1, -512, 8191, 1, -4193792, 0, -4193792, 0, -4193792, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0));
        // four beats with a bubble between beats 2 and 3
        tbl.push_back(mk(1, 1, 1, 0, 3, -5));
        tbl.push_back(mk(1, 1, 0, 0, 3, -5));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 3, -5));
        tbl.push_back(mk(1, 1, 0, 1, 3, -5, 1, -60, 0, -60, 0, -60, 0));
        // back-to-back groups, no gap
        tbl.push_back(mk(1, 1, 1, 1, 2, 3, 1, 6, 0, 6, 0, 6, 0));
        tbl.push_back(mk(1, 1, 1, 0, 4, 5));
        tbl.push_back(mk(1, 1, 0, 1, 1, 1, 1, 21, 0, 21, 0, 21, 0));
        // overflow: 32-bit exact, 24-bit clamps or wraps; then a clean group
        tbl.push_back(mk(1, 1, 1, 0, -512, -8192));
        tbl.push_back(mk(1, 1, 0, 1, -512, -8192, 1, 8388608, 0, 8388607, 1, -8388608, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 1, 0));
        // five-cycle stall mid-group with junk beats presented during the stall
        tbl.push_back(mk(1, 1, 1, 0, 3, -5));
        tbl.push_back(mk(1, 1, 0, 0, 3, -5));
        tbl.push_back(mk(0, 1, 1, 1, 100, 100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, -7, 9));
        tbl.push_back(mk(0, 0, 1, 0, 11, 11));
        tbl.push_back(mk(0, 1, 1, 0, 55, -3));
        tbl.push_back(mk(1, 1, 0, 0, 3, -5));
        tbl.push_back(mk(1, 1, 0, 1, 3, -5, 1, -60, 0, -60, 0, -60, 0));

        repeat (2) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;
        ce    = 1'b1;

        foreach (tbl[n]) apply(tbl[n]);
        idle(8);

        // reset lands while a result is on the outputs and another group is in flight
        apply(mk(1, 1, 1, 1, 5, 5));
        apply(mk(1, 1, 1, 0, 9, 9));
        apply(mk(1, 1, 0, 0, 2, 2));
        idle(2);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        // first beat after reset without in_first still starts a fresh group
        apply(mk(1, 1, 0, 1, 7, 7, 1, 49, 0, 49, 0, 49, 0));
        idle(8);
        check("table_pending", 0, tq.size(), 0);
        tmode = 1'b0;

        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            ce       = ($urandom_range(0, 7) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_first = ($urandom_range(0, 4) == 0);
            in_last  = ($urandom_range(0, 3) == 0);
            din0     = 10'($urandom);
            din1     = 14'($urandom);
        end
        idle(10);
        check("model_pending", 0, eq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
